// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 Hz raster timing. Free-running pixel/line counters
//            with hsync/vsync/blank delayed to line up with the renderers'
//            registered pixel output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2     // legal range 0..7
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       blank_d,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       line_start,
    output logic [7:0] frame_count
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_h_last       = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last       = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_vis        = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis        = 10'(V_VISIBLE);
    localparam logic [9:0] c_h_sync_start = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_h_sync_end   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_v_sync_start = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_v_sync_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic [7:0] r_frame_count;
    logic       w_blank;
    logic       w_hs_raw;
    logic       w_vs_raw;

    // Raster counters: hc every clock, vc and frame count when the line wraps
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_count <= '0;
        end else if (r_hc == c_h_last) begin
            r_hc <= '0;
            if (r_vc == c_v_last) begin
                r_vc          <= '0;
                r_frame_count <= r_frame_count + 8'd1;
            end else begin
                r_vc <= r_vc + 10'd1;
            end
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    // Undelayed position decodes (sync pulses are active-low)
    always_comb begin
        w_blank  = (r_hc < c_h_vis) && (r_vc < c_v_vis);
        w_hs_raw = !((r_hc >= c_h_sync_start) && (r_hc < c_h_sync_end));
        w_vs_raw = !((r_vc >= c_v_sync_start) && (r_vc < c_v_sync_end));
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = w_blank;
    assign frame_count = r_frame_count;
    assign frame_start = (r_hc == 10'd0) && (r_vc == 10'd0);
    assign line_start  = (r_hc == 10'd0);

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync   = w_hs_raw;
            assign vsync   = w_vs_raw;
            assign blank_d = w_blank;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_pipe;
            logic [PIPE_DELAY-1:0] r_vs_pipe;
            logic [PIPE_DELAY-1:0] r_blank_pipe;

            // Shift register; reset loads inactive levels so no partial pulse escapes
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    r_hs_pipe    <= '1;
                    r_vs_pipe    <= '1;
                    r_blank_pipe <= '0;
                end else begin
                    r_hs_pipe[0]    <= w_hs_raw;
                    r_vs_pipe[0]    <= w_vs_raw;
                    r_blank_pipe[0] <= w_blank;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_pipe[i]    <= r_hs_pipe[i-1];
                        r_vs_pipe[i]    <= r_vs_pipe[i-1];
                        r_blank_pipe[i] <= r_blank_pipe[i-1];
                    end
                end
            end

            assign hsync   = r_hs_pipe[PIPE_DELAY-1];
            assign vsync   = r_vs_pipe[PIPE_DELAY-1];
            assign blank_d = r_blank_pipe[PIPE_DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen. One full-size instance
//            (PIPE_DELAY=2) plus two small-geometry instances (PIPE_DELAY=0
//            and 7) so frame-level behaviour fits in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       blank_d;
        logic       hsync;
        logic       vsync;
        logic       fs;
        logic       ls;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        longint k;
        out_t   exp;
    } vec_t;

    // Small geometry: 15 pixels x 11 lines = 165 cycles per frame
    localparam int SH_V = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_V = 6, SV_F = 1, SV_S = 2, SV_B = 2;
    localparam longint S_FRAME = 165;

    logic   vga_clk = 1'b0;
    logic   rst_a   = 1'b0;
    logic   rst_s   = 1'b0;
    int     checks  = 0;
    int     errors  = 0;
    longint ka = 0;
    longint ks = 0;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic       a_bl, a_bd, a_hs, a_vs, a_fs, a_ls;
    logic       b_bl, b_bd, b_hs, b_vs, b_fs, b_ls;
    logic       c_bl, c_bd, c_hs, c_vs, c_fs, c_ls;
    logic [7:0] a_fc, b_fc, c_fc;
    out_t       oa, ob, oc;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_a (
        .vga_clk(vga_clk), .reset(rst_a), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
        .blank_d(a_bd), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs),
        .line_start(a_ls), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .PIPE_DELAY(0)
    ) dut_b (
        .vga_clk(vga_clk), .reset(rst_s), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
        .blank_d(b_bd), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs),
        .line_start(b_ls), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .PIPE_DELAY(7)
    ) dut_c (
        .vga_clk(vga_clk), .reset(rst_s), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
        .blank_d(c_bd), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs),
        .line_start(c_ls), .frame_count(c_fc)
    );

    assign oa = {a_x, a_y, a_bl, a_bd, a_hs, a_vs, a_fs, a_ls, a_fc};
    assign ob = {b_x, b_y, b_bl, b_bd, b_hs, b_vs, b_fs, b_ls, b_fc};
    assign oc = {c_x, c_y, c_bl, c_bd, c_hs, c_vs, c_fs, c_ls, c_fc};

    // Cycles elapsed since the most recent reset release
    always @(posedge vga_clk or posedge rst_a) begin
        if (rst_a) ka <= 0;
        else       ka <= ka + 1;
    end

    always @(posedge vga_clk or posedge rst_s) begin
        if (rst_s) ks <= 0;
        else       ks <= ks + 1;
    end

    // Reference: position k cycles after reset, delayed outputs look d cycles back
    function automatic out_t model(longint k, longint hv, longint hf, longint hsw, longint hb,
                                   longint vv, longint vf, longint vsw, longint vb, longint d);
        longint ht, vt, h, v;
        out_t   o;
        ht      = hv + hf + hsw + hb;
        vt      = vv + vf + vsw + vb;
        h       = k % ht;
        v       = (k / ht) % vt;
        o.x     = 10'(h);
        o.y     = 10'(v);
        o.fc    = 8'((k / (ht * vt)) % 256);
        o.fs    = (h == 0) && (v == 0);
        o.ls    = (h == 0);
        o.blank = (h < hv) && (v < vv);
        if (k >= d) begin
            h         = (k - d) % ht;
            v         = ((k - d) / ht) % vt;
            o.blank_d = (h < hv) && (v < vv);
            o.hsync   = !((h >= hv + hf) && (h < hv + hf + hsw));
            o.vsync   = !((v >= vv + vf) && (v < vv + vf + vsw));
        end else begin
            o.blank_d = 1'b0;
            o.hsync   = 1'b1;
            o.vsync   = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t mk_out(longint x, longint y, bit bl, bit bd, bit hs, bit vs,
                                    bit fs, bit ls, longint fc);
        out_t o;
        o.x = 10'(x); o.y = 10'(y); o.blank = bl; o.blank_d = bd;
        o.hsync = hs; o.vsync = vs; o.fs = fs; o.ls = ls; o.fc = 8'(fc);
        return o;
    endfunction

    function automatic vec_t mk(longint k, longint x, longint y, bit bl, bit bd, bit hs, bit vs,
                                bit fs, bit ls, longint fc);
        vec_t r;
        r.k   = k;
        r.exp = mk_out(x, y, bl, bd, hs, vs, fs, ls, fc);
        return r;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d blank=%0b blank_d=%0b hsync=%0b vsync=%0b fs=%0b ls=%0b fc=%0d, want x=%0d y=%0d blank=%0b blank_d=%0b hsync=%0b vsync=%0b fs=%0b ls=%0b fc=%0d",
                     name, act.x, act.y, act.blank, act.blank_d, act.hsync, act.vsync, act.fs, act.ls, act.fc,
                     exp.x, exp.y, exp.blank, exp.blank_d, exp.hsync, exp.vsync, exp.fs, exp.ls, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_ka(input longint target);
        int guard = 0;
        do begin
            @(negedge vga_clk);
            guard++;
        end while (ka < target && guard < 50000);
        check_int($sformatf("wait_a_k%0d", target), ka, target);
    endtask

    task automatic wait_ks(input longint target);
        int guard = 0;
        do begin
            @(negedge vga_clk);
            guard++;
        end while (ks < target && guard < 60000);
        check_int($sformatf("wait_s_k%0d", target), ks, target);
    endtask

    // Cycle-by-cycle comparison of every instance against the reference
    out_t hist_q[$];
    always @(negedge vga_clk) begin
        check_out("model_a", oa, model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 2));
        check_out("model_b", ob, model(ks, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 0));
        check_out("model_c", oc, model(ks, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 7));
        if (rst_s) begin
            hist_q.delete();
        end else begin
            hist_q.push_back(ob);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            if (hist_q.size() == 8)
                check_int("delay7_vs_delay0", {oc.hsync, oc.vsync, oc.blank_d},
                          {hist_q[0].hsync, hist_q[0].vsync, hist_q[0].blank_d});
        end
    end

    initial begin
        vec_t   tbl[$];
        out_t   rst_exp;
        int     first_low, low_cnt, ls_cnt, fs_cnt, first_blank0;
        int     c_first_low, c_low_cnt;

        // Full-size instance, PIPE_DELAY=2, values derived by hand from the timing rules
        //                k    x    y  bl bd hs vs fs ls fc
        tbl.push_back(mk(  0,   0, 0, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(  1,   1, 0, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(  2,   2, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(639, 639, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(640, 640, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(641, 641, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(642, 642, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(657, 657, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(658, 658, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(753, 753, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(754, 754, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(799, 799, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(800,   0, 1, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(801,   1, 1, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(802,   2, 1, 1, 1, 1, 1, 0, 0, 0));
        rst_exp = mk_out(0, 0, 1, 0, 1, 1, 1, 1, 0);

        #1;
        rst_a = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge vga_clk);
        #2 rst_a = 1'b0;

        foreach (tbl[i]) begin
            wait_ka(tbl[i].k);
            check_out($sformatf("vec_k%0d", tbl[i].k), oa, tbl[i].exp);
        end

        // Reset while hsync is low (hc=700, vc=1): sync must go inactive at once
        wait_ka(1500);
        @(posedge vga_clk);
        #2 rst_a = 1'b1;
        #1 check_out("reset_in_hsync", oa, rst_exp);
        repeat (2) @(posedge vga_clk);
        #2 rst_a = 1'b0;

        // Reset mid-line at hc=300, vc=1 (blank_d high beforehand)
        wait_ka(1100);
        check_int("pre_reset_blank_d", a_bd, 1);
        @(posedge vga_clk);
        #2 rst_a = 1'b1;
        #1 check_out("reset_mid_line", oa, rst_exp);
        repeat (2) @(posedge vga_clk);
        #2 rst_a = 1'b0;
        wait_ka(0);
        check_int("resume_x0", a_x, 0);
        wait_ka(1);
        check_int("resume_x1", a_x, 1);

        // Reset just before hsync: no truncated pulse, next one is full length
        wait_ka(650);
        @(posedge vga_clk);
        #2 rst_a = 1'b1;
        repeat (4) @(posedge vga_clk);
        #2 rst_a = 1'b0;
        first_low = -1; low_cnt = 0; ls_cnt = 0; first_blank0 = -1;
        repeat (800) begin
            @(negedge vga_clk);
            if (!a_hs) begin
                if (first_low < 0) first_low = int'(ka);
                low_cnt++;
            end
            if (!a_bl && first_blank0 < 0) first_blank0 = int'(ka);
            if (a_ls) ls_cnt++;
        end
        check_int("hsync_first_low", first_low, 658);
        check_int("hsync_low_width", low_cnt, 96);
        check_int("blank_fall_hc", first_blank0, 640);
        check_int("line_start_per_line", ls_cnt, 1);
        @(posedge vga_clk);
        #2 rst_a = 1'b1;

        // Small instances: random asynchronous resets at arbitrary points
        @(posedge vga_clk);
        #2 rst_s = 1'b0;
        repeat (40) begin
            repeat ($urandom_range(1, 300)) @(posedge vga_clk);
            #($urandom_range(1, 3)) rst_s = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge vga_clk);
            #2 rst_s = 1'b0;
        end

        // Clean run: one frame of measurements, then the 255 -> 0 wrap
        @(posedge vga_clk);
        #2 rst_s = 1'b1;
        @(posedge vga_clk);
        #2 rst_s = 1'b0;
        first_low = -1; low_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        c_first_low = -1; c_low_cnt = 0;
        repeat (int'(S_FRAME)) begin
            @(negedge vga_clk);
            if (!b_vs) begin
                if (first_low < 0) first_low = int'(ks);
                low_cnt++;
            end
            if (!c_vs) begin
                if (c_first_low < 0) c_first_low = int'(ks);
                c_low_cnt++;
            end
            if (b_ls) ls_cnt++;
            if (b_fs) fs_cnt++;
        end
        check_int("d0_vsync_first_low", first_low, 105);
        check_int("d0_vsync_low_width", low_cnt, 30);
        check_int("d7_vsync_first_low", c_first_low, 112);
        check_int("d7_vsync_low_width", c_low_cnt, 30);
        check_int("line_starts_per_frame", ls_cnt, 11);
        check_int("frame_starts_per_frame", fs_cnt, 1);

        wait_ks(256 * S_FRAME - 1);
        check_out("wrap_last_pixel", ob, mk_out(14, 10, 0, 0, 1, 1, 0, 0, 255));
        wait_ks(256 * S_FRAME);
        check_out("wrap_first_pixel", ob, mk_out(0, 0, 1, 1, 1, 1, 1, 1, 0));
        check_int("wrap_d7_frame_count", c_fc, 0);

        @(negedge vga_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates raster timing for 640x480@60 Hz VGA (25 MHz pixel clock).
- Drives DrawX/DrawY/blank into the per-pixel renderers (background ROM/palette blocks, sprite layers).
- Drives hsync/vsync to the DAC/connector. Sync outputs are delayed by a configurable number of cycles so they line up with the renderers' registered pixel output.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIPE_DELAY, 2, cycles of delay applied to hsync/vsync/blank_d (ROM read 1 + colour register 1); legal range 0..7

Ports:
- vga_clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- DrawX  output  10  current horizontal counter (0..H_TOTAL-1)
- DrawY  output  10  current vertical counter (0..V_TOTAL-1)
- blank  output  1  1 = active video at (DrawX, DrawY), undelayed
- blank_d  output  1  blank delayed PIPE_DELAY cycles
- hsync  output  1  active-low horizontal sync, delayed PIPE_DELAY cycles
- vsync  output  1  active-low vertical sync, delayed PIPE_DELAY cycles
- frame_start  output  1  1 while DrawX==0 and DrawY==0
- line_start  output  1  1 while DrawX==0
- frame_count  output  8  completed-frame counter, wraps modulo 256

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525)
- Counters hc and vc are registers and drive DrawX and DrawY directly.
- Each vga_clk edge:
  - If hc==H_TOTAL-1: hc<=0. Otherwise hc<=hc+1.
  - When hc wraps: if vc==V_TOTAL-1, then vc<=0 and frame_count<=frame_count+1 (8-bit wrap, 255->0); otherwise vc<=vc+1.
- Combinational decodes from the current hc/vc:
  - blank = (hc<H_VISIBLE) && (vc<V_VISIBLE)
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1
  - frame_start and line_start are decoded directly from hc/vc.
- Delay pipeline:
  - hs_raw, vs_raw and blank pass through a PIPE_DELAY-stage shift register to produce hsync, vsync and blank_d.
  - PIPE_DELAY=0 means a direct combinational pass-through.
  - Required alignment: the sync edge appears on hsync exactly PIPE_DELAY cycles after the hc value that caused it.
- Reset (asynchronous, takes effect mid-frame at any time):
  - hc=0, vc=0, frame_count=0.
  - Every delay stage is loaded with its inactive value: hs=1, vs=1, blank_d=0.
  - Consequence: during reset and immediately after it, DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, hsync=1, vsync=1, blank_d=0.
  - The first cycle after reset deassertion shows (0,0); counting resumes on the following edge.
- No back-pressure or enable: the counters advance on every clock.

Test Plan:
- Reset asserted mid-line (hc=300, vc=100) -> same cycle: DrawX=0, DrawY=0, frame_count=0, hsync=vsync=1, blank_d=0; counting resumes from 0 after release.
- Free-run one line, PIPE_DELAY=2 -> blank falls at hc=640. hsync falls 2 cycles after hc=656 and stays low exactly 96 cycles. Line period is 800 cycles; line_start pulses once per 800.
- Free-run one frame -> vsync low for exactly 2×800=1600 cycles, beginning 2 cycles after (hc=0, vc=490). blank=0 for all vc>=480. Frame period is 420000 cycles; frame_start pulses once.
- Wrap boundary at (hc=799, vc=524) -> next cycle (0,0), frame_start=1, frame_count increments. Starting from frame_count=255 it wraps to 0.
- PIPE_DELAY=0 build -> hsync==hs_raw and blank_d==blank in the same cycle. PIPE_DELAY=7 -> same waveforms shifted by 7 cycles.
- Reset released at the cycle where hc would be 655 (just before hsync) -> hsync stays 1 until the next line's hc=656+PIPE_DELAY; there is no truncated sync pulse.
